// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping,
// datapath enables and mux selects, illegal-opcode trap and retire counter.
module multicycle_ctrl #(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_sel,
    output logic [2:0]  imm_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned CNT_W   = 32;

    localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] S_WB     = 3'd4;
    localparam logic [STATE_W-1:0] S_TRAP   = 3'd5;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd6;

    localparam logic [CLASS_W-1:0] CL_NONE = 3'd0;
    localparam logic [CLASS_W-1:0] CL_R    = 3'd1;
    localparam logic [CLASS_W-1:0] CL_I    = 3'd2;
    localparam logic [CLASS_W-1:0] CL_L    = 3'd3;
    localparam logic [CLASS_W-1:0] CL_S    = 3'd4;
    localparam logic [CLASS_W-1:0] CL_B    = 3'd5;
    localparam logic [CLASS_W-1:0] CL_JAL  = 3'd6;
    localparam logic [CLASS_W-1:0] CL_JALR = 3'd7;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CLASS_W-1:0] cls_q, dec_class;
    logic               illegal_q;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               unused_instr;

    // Only the opcode field steers the sequencer.
    assign unused_instr = ^instr[31:7];

    // Immediate format selected by an instruction class.
    function automatic logic [2:0] imm_of(input logic [CLASS_W-1:0] cls);
        case (cls)
            CL_I, CL_L, CL_JALR: imm_of = 3'd1;
            CL_S:                imm_of = 3'd2;
            CL_B:                imm_of = 3'd3;
            CL_JAL:              imm_of = 3'd4;
            default:             imm_of = 3'd0;
        endcase
    endfunction

    // ALU B operand is the immediate for address and immediate arithmetic.
    function automatic logic alu_imm_of(input logic [CLASS_W-1:0] cls);
        alu_imm_of = (cls == CL_I) || (cls == CL_L) || (cls == CL_S) || (cls == CL_JALR);
    endfunction

    // Opcode classification; CL_NONE marks an unsupported opcode.
    always_comb begin
        dec_class = CL_NONE;
        case (instr[6:0])
            7'b0110011: dec_class = CL_R;
            7'b0010011: dec_class = CL_I;
            7'b0000011: dec_class = CL_L;
            7'b0100011: dec_class = CL_S;
            7'b1100011: dec_class = CL_B;
            7'b1101111: dec_class = CL_JAL;
            7'b1100111: dec_class = CL_JALR;
            default:    dec_class = CL_NONE;
        endcase
    end

    // State, class, trap flag and retire counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
            cls_q     <= CL_NONE;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_class;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next state and control outputs; reset forces every output low at once.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_we       = 1'b0;
        mdr_we      = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        alu_src_sel = 1'b0;
        imm_sel     = 3'd0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_sel = imm_of(dec_class);
                state_d = (dec_class == CL_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                imm_sel     = imm_of(cls_q);
                alu_src_sel = alu_imm_of(cls_q);
                case (cls_q)
                    CL_B: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? 2'd1 : 2'd0;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_L, CL_S: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // Operand selects held so the combinational address stays stable.
                imm_sel     = imm_of(cls_q);
                alu_src_sel = alu_imm_of(cls_q);
                mem_req     = 1'b1;
                addr_sel    = 1'b1;
                mem_we      = (cls_q == CL_S);
                if (mem_ready) begin
                    if (cls_q == CL_S) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                imm_sel     = imm_of(cls_q);
                alu_src_sel = alu_imm_of(cls_q);
                rf_we       = 1'b1;
                pc_we       = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
                case (cls_q)
                    CL_L:    wb_sel = 2'd1;
                    CL_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                    CL_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    default: wb_sel = 2'd0;
                endcase
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        state   = state_q;
        illegal = illegal_q;
        instret = instret_q;

        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            ir_we       = 1'b0;
            mdr_we      = 1'b0;
            rf_we       = 1'b0;
            wb_sel      = 2'd0;
            alu_src_sel = 1'b0;
            imm_sel     = 3'd0;
            pc_we       = 1'b0;
            pc_sel      = 2'd0;
            illegal     = 1'b0;
            state       = 3'd0;
            instret     = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of state and controls.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we;
    logic [1:0]  wb_sel;
    logic        alu_src_sel;
    logic [2:0]  imm_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_src_sel(alu_src_sel), .imm_sel(imm_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal), .state(state),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Packed compare of {state, controls, illegal}; sampled mid-cycle.
    task automatic expc(input string tag, input int st, input int mreq, input int mwe,
                        input int asel, input int irwe, input int mdrwe, input int rfwe,
                        input int wbs, input int alus, input int imms, input int pcwe,
                        input int pcs, input int ill);
        logic [18:0] obs, expv;
        #1;
        obs  = {state, mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, wb_sel,
                alu_src_sel, imm_sel, pc_we, pc_sel, illegal};
        expv = {3'(st), 1'(mreq), 1'(mwe), 1'(asel), 1'(irwe), 1'(mdrwe), 1'(rfwe),
                2'(wbs), 1'(alus), 3'(imms), 1'(pcwe), 2'(pcs), 1'(ill)};
        chk(tag, 32'(obs), 32'(expv));
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; branch_taken = 1'b0;

        // Reset held two cycles
        step(); expc("rst_c0", 0,0,0,0,0,0,0,0,0,0,0,0,0); chk("rst_instret0", instret, 32'd0);
        step(); expc("rst_c1", 0,0,0,0,0,0,0,0,0,0,0,0,0);

        // addi x1,x0,5
        rst = 1'b0; instr = 32'h00500093;
        expc("addi_F", 0,1,0,0,1,0,0,0,0,0,0,0,0); chk("post_rst_instret", instret, 32'd0);
        step(); expc("addi_D", 1,0,0,0,0,0,0,0,0,1,0,0,0);
        step(); expc("addi_E", 2,0,0,0,0,0,0,0,1,1,0,0,0);
        step(); expc("addi_W", 4,0,0,0,0,0,1,0,1,1,1,0,0); chk("addi_instret_pre", instret, 32'd0);

        // lw with three wait cycles on the data access
        step(); instr = 32'h0000A103; chk("addi_instret_post", instret, 32'd1);
        expc("lw_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("lw_D", 1,0,0,0,0,0,0,0,0,1,0,0,0);
        step(); mem_ready = 1'b0; expc("lw_E", 2,0,0,0,0,0,0,0,1,1,0,0,0);
        step(); expc("lw_M1", 3,1,0,1,0,0,0,0,1,1,0,0,0);
        step(); expc("lw_M2", 3,1,0,1,0,0,0,0,1,1,0,0,0);
        step(); expc("lw_M3", 3,1,0,1,0,0,0,0,1,1,0,0,0);
        step(); mem_ready = 1'b1; expc("lw_M4", 3,1,0,1,0,1,0,0,1,1,0,0,0);
        step(); expc("lw_W", 4,0,0,0,0,0,1,1,1,1,1,0,0);

        // sw
        step(); instr = 32'h0020A223; chk("lw_instret", instret, 32'd2);
        expc("sw_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("sw_D", 1,0,0,0,0,0,0,0,0,2,0,0,0);
        step(); expc("sw_E", 2,0,0,0,0,0,0,0,1,2,0,0,0);
        step(); expc("sw_M", 3,1,1,1,0,0,0,0,1,2,1,0,0);

        // beq taken
        step(); instr = 32'h00000463; branch_taken = 1'b1; chk("sw_instret", instret, 32'd3);
        expc("beqT_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("beqT_D", 1,0,0,0,0,0,0,0,0,3,0,0,0);
        step(); expc("beqT_E", 2,0,0,0,0,0,0,0,0,3,1,1,0);

        // beq not taken
        step(); branch_taken = 1'b0; chk("beqT_instret", instret, 32'd4);
        expc("beqN_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("beqN_D", 1,0,0,0,0,0,0,0,0,3,0,0,0);
        step(); expc("beqN_E", 2,0,0,0,0,0,0,0,0,3,1,0,0);

        // jal
        step(); instr = 32'h010000EF; chk("beqN_instret", instret, 32'd5);
        expc("jal_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("jal_D", 1,0,0,0,0,0,0,0,0,4,0,0,0);
        step(); expc("jal_E", 2,0,0,0,0,0,0,0,0,4,0,0,0);
        step(); expc("jal_W", 4,0,0,0,0,0,1,2,0,4,1,1,0);

        // jalr
        step(); instr = 32'h000080E7; chk("jal_instret", instret, 32'd6);
        expc("jalr_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("jalr_D", 1,0,0,0,0,0,0,0,0,1,0,0,0);
        step(); expc("jalr_E", 2,0,0,0,0,0,0,0,1,1,0,0,0);
        step(); expc("jalr_W", 4,0,0,0,0,0,1,2,1,1,1,2,0);

        // Fetch wait, then illegal opcode 0x00000000
        step(); instr = 32'h00000000; mem_ready = 1'b0; chk("jalr_instret", instret, 32'd7);
        expc("fw_1", 0,1,0,0,0,0,0,0,0,0,0,0,0);
        step(); expc("fw_2", 0,1,0,0,0,0,0,0,0,0,0,0,0);
        step(); mem_ready = 1'b1; expc("ill_F", 0,1,0,0,1,0,0,0,0,0,0,0,0);
        step(); expc("ill_D", 1,0,0,0,0,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 12; i++) begin
            step(); expc($sformatf("trap_%0d", i), 5,0,0,0,0,0,0,0,0,0,0,0,1);
            chk($sformatf("trap_instret_%0d", i), instret, 32'd7);
        end

        // Reset leaves the trap and clears illegal and instret
        rst = 1'b1; expc("trap_rst", 0,0,0,0,0,0,0,0,0,0,0,0,0);
        step(); rst = 1'b0; mem_ready = 1'b0;
        expc("after_trap_F", 0,1,0,0,0,0,0,0,0,0,0,0,0); chk("after_trap_instret", instret, 32'd0);

        // Reset in the middle of a fetch wait drops mem_req immediately
        step(); expc("fw_pre_rst", 0,1,0,0,0,0,0,0,0,0,0,0,0);
        rst = 1'b1; expc("fw_rst", 0,0,0,0,0,0,0,0,0,0,0,0,0);
        step(); rst = 1'b0; mem_ready = 1'b1;
        expc("fw_rst_after", 0,1,0,0,1,0,0,0,0,0,0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
